// File: rtl/fifo_thresh.sv
// Synchronous FIFO with first-word fall-through output, occupancy count,
// programmable almost-full / almost-empty thresholds and sticky
// overflow / underflow error flags.
module fifo_thresh #(
   parameter int WIDTH     = 32,
   parameter int DEPTH     = 16,
   parameter int AFULL_TH  = DEPTH - 2,
   parameter int AEMPTY_TH = 1
) (
   input  logic                         clk,
   input  logic                         res_n,
   input  logic                         shift_in,
   input  logic                         shift_out,
   input  logic [WIDTH-1:0]             data_in,
   input  logic                         clr_err,
   output logic [WIDTH-1:0]             data_out,
   output logic                         full,
   output logic                         empty,
   output logic                         almost_full,
   output logic                         almost_empty,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         overflow,
   output logic                         underflow
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_write;
   logic             do_read;
   logic             ovf_event;
   logic             unf_event;

   // Pointer advance with wrap at DEPTH-1 (DEPTH need not be a power of two).
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Status flags decoded straight from the registered occupancy.
   always_comb begin
      full         = (count == CW'(DEPTH));
      empty        = (count == '0);
      almost_full  = (count >= CW'(AFULL_TH));
      almost_empty = (count <= CW'(AEMPTY_TH));
   end

   // Request acceptance: a write into a full queue is allowed only when a
   // read frees the head slot in the same cycle; reads need a non-empty queue.
   always_comb begin
      do_read   = shift_out && !empty;
      do_write  = shift_in && (!full || shift_out);
      ovf_event = shift_in && full && !shift_out;
      unf_event = shift_out && empty;
   end

   // Fall-through head word, forced to zero while nothing is queued.
   always_comb begin
      data_out = empty ? '0 : mem[rd_ptr];
   end

   // Storage array: no reset, only written on an accepted write.
   always_ff @(posedge clk) begin
      if (do_write) begin
         mem[wr_ptr] <= data_in;
      end
   end

   // Pointers and occupancy count.
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_write) begin
            wr_ptr <= ptr_inc(wr_ptr);
         end
         if (do_read) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         case ({do_write, do_read})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Sticky error flags; a new error wins over a simultaneous clear.
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= (overflow  && !clr_err) || ovf_event;
         underflow <= (underflow && !clr_err) || unf_event;
      end
   end

endmodule

// File: tb/tb_fifo_thresh.sv
// Randomized and directed bench for fifo_thresh (WIDTH=8, DEPTH=4,
// AFULL_TH=3, AEMPTY_TH=1) against a queue-based reference model.
module tb_fifo_thresh;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
   localparam int AFT   = 3;
   localparam int AET   = 1;

   logic             clk = 1'b0;
   logic             res_n;
   logic             shift_in;
   logic             shift_out;
   logic [WIDTH-1:0] data_in;
   logic             clr_err;
   logic [WIDTH-1:0] data_out;
   logic             full;
   logic             empty;
   logic             almost_full;
   logic             almost_empty;
   logic [2:0]       count;
   logic             overflow;
   logic             underflow;

   int n_checks = 0;
   int n_fail   = 0;
   int pushed   = 0;

   // Reference model: a plain queue plus two sticky bits.
   logic [7:0] mq[$];
   bit         m_ovf;
   bit         m_unf;

   fifo_thresh #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_TH(AFT), .AEMPTY_TH(AET)
   ) dut (
      .clk(clk), .res_n(res_n), .shift_in(shift_in), .shift_out(shift_out),
      .data_in(data_in), .clr_err(clr_err), .data_out(data_out),
      .full(full), .empty(empty), .almost_full(almost_full),
      .almost_empty(almost_empty), .count(count),
      .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_outputs();
      int sz;
      sz = mq.size();
      chk("count",        32'(count),        32'(sz));
      chk("empty",        32'(empty),        32'(sz == 0));
      chk("full",         32'(full),         32'(sz == DEPTH));
      chk("almost_full",  32'(almost_full),  32'(sz >= AFT));
      chk("almost_empty", 32'(almost_empty), 32'(sz <= AET));
      chk("data_out",     32'(data_out),     (sz == 0) ? 32'h0 : 32'(mq[0]));
      chk("overflow",     32'(overflow),     32'(m_ovf));
      chk("underflow",    32'(underflow),    32'(m_unf));
   endtask

   // Apply the FIFO rules to the model for one clock edge.
   task automatic model_update(input bit si, input bit so, input logic [7:0] d, input bit clr);
      int  sz;
      bit  wr_ok;
      bit  rd_ok;
      sz    = mq.size();
      rd_ok = so && (sz > 0);
      wr_ok = si && ((sz < DEPTH) || so);
      if (clr) begin
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end
      if (si && (sz == DEPTH) && !so) m_ovf = 1'b1;
      if (so && (sz == 0))            m_unf = 1'b1;
      if (rd_ok) void'(mq.pop_front());
      if (wr_ok) begin
         mq.push_back(d);
         pushed++;
      end
   endtask

   // One cycle: check current outputs, drive requests, clock, update model.
   task automatic step(input bit si, input bit so, input logic [7:0] d, input bit clr);
      check_outputs();
      shift_in  = si;
      shift_out = so;
      data_in   = d;
      clr_err   = clr;
      @(posedge clk);
      model_update(si, so, d, clr);
      @(negedge clk);
      shift_in  = 1'b0;
      shift_out = 1'b0;
      clr_err   = 1'b0;
   endtask

   task automatic model_reset();
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
   endtask

   initial begin
      int  cyc;
      int  p_in;
      int  p_out;
      bit  si;
      bit  so;
      bit  cl;

      res_n     = 1'b0;
      shift_in  = 1'b0;
      shift_out = 1'b0;
      data_in   = '0;
      clr_err   = 1'b0;
      model_reset();

      // Reset state
      #3;
      check_outputs();
      @(negedge clk);
      res_n = 1'b1;

      // Fill to full; head stays 0x11
      step(1, 0, 8'h11, 0);
      step(1, 0, 8'h22, 0);
      step(1, 0, 8'h33, 0);
      chk("afull_at3", 32'(almost_full), 32'h1);
      step(1, 0, 8'h44, 0);
      chk("full_at4", 32'(full), 32'h1);
      chk("head_11", 32'(data_out), 32'h11);

      // Write while full is dropped and flags overflow
      step(1, 0, 8'h55, 0);
      chk("ovf_set", 32'(overflow), 32'h1);
      chk("cnt_hold", 32'(count), 32'h4);
      chk("rd_11", 32'(data_out), 32'h11);
      step(0, 1, 8'h00, 0);
      chk("rd_22", 32'(data_out), 32'h22);
      step(0, 1, 8'h00, 0);
      step(0, 1, 8'h00, 0);
      chk("rd_44", 32'(data_out), 32'h44);
      step(0, 1, 8'h00, 0);
      chk("drained_dout", 32'(data_out), 32'h0);
      step(0, 0, 8'h00, 1);

      // Simultaneous push/pop while full, then drain across the wrap
      step(1, 0, 8'h11, 0);
      step(1, 0, 8'h22, 0);
      step(1, 0, 8'h33, 0);
      step(1, 0, 8'h44, 0);
      step(1, 1, 8'h66, 0);
      chk("full_both_cnt", 32'(count), 32'h4);
      chk("full_both_ovf", 32'(overflow), 32'h0);
      chk("full_both_head", 32'(data_out), 32'h22);
      step(0, 1, 8'h00, 0);
      step(0, 1, 8'h00, 0);
      step(0, 1, 8'h00, 0);
      chk("wrap_66", 32'(data_out), 32'h66);
      step(0, 1, 8'h00, 0);

      // Push/pop on empty: write accepted, underflow raised, then cleared
      step(1, 1, 8'h77, 0);
      chk("emp_both_dout", 32'(data_out), 32'h77);
      chk("emp_both_unf", 32'(underflow), 32'h1);
      step(0, 0, 8'h00, 1);
      chk("unf_clr", 32'(underflow), 32'h0);
      // Error coinciding with clear keeps the flag set
      step(0, 1, 8'h00, 0);
      step(0, 1, 8'h00, 1);
      chk("unf_wins", 32'(underflow), 32'h1);
      step(0, 0, 8'h00, 1);

      // Asynchronous reset mid-operation at count 3
      step(1, 0, 8'hA1, 0);
      step(1, 0, 8'hA2, 0);
      step(1, 0, 8'hA3, 0);
      check_outputs();
      #1;
      res_n = 1'b0;
      model_reset();
      #1;
      check_outputs();
      shift_in = 1'b1;
      data_in  = 8'hEE;
      @(posedge clk);
      #1;
      check_outputs();
      @(negedge clk);
      shift_in = 1'b0;
      res_n    = 1'b1;
      step(1, 0, 8'h99, 0);
      chk("post_rst_dout", 32'(data_out), 32'h99);
      chk("post_rst_cnt", 32'(count), 32'h1);

      // Randomized traffic until 1000 more words accepted
      pushed = 0;
      cyc    = 0;
      while (pushed < 1000 && cyc < 20000) begin
         p_in  = ((cyc / 150) % 2 == 0) ? 75 : 35;
         p_out = ((cyc / 150) % 2 == 0) ? 35 : 75;
         si = ($urandom_range(0, 99) < p_in);
         so = ($urandom_range(0, 99) < p_out);
         cl = ($urandom_range(0, 99) < 5);
         step(si, so, 8'($urandom), cl);
         cyc++;
      end
      chk("random_budget", 32'(pushed >= 1000), 32'h1);
      check_outputs();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_thresh.md
FIFO_THRESH -- requirements
Module: fifo_thresh

Interface
REQ-001 Parameter WIDTH, default 32, data word width in bits.
REQ-002 Parameter DEPTH, default 16, storage entries; any integer >= 2, power of two not required.
REQ-003 Parameter AFULL_TH, default DEPTH-2, almost_full threshold; legal range 1..DEPTH.
REQ-004 Parameter AEMPTY_TH, default 1, almost_empty threshold; legal range 0..DEPTH-1.
REQ-005 Port clk, input, 1, sole clock; all state updates on rising edge.
REQ-006 Port res_n, input, 1, reset; asynchronous, active-low.
REQ-007 Port shift_in, input, 1, write request for data_in.
REQ-008 Port shift_out, input, 1, read request; pops the word currently on data_out.
REQ-009 Port data_in, input, WIDTH, write data.
REQ-010 Port clr_err, input, 1, synchronous clear of sticky error flags.
REQ-011 Port data_out, output, WIDTH, head-of-queue word (first-word fall-through).
REQ-012 Port full, output, 1, count == DEPTH.
REQ-013 Port empty, output, 1, count == 0.
REQ-014 Port almost_full, output, 1, count >= AFULL_TH.
REQ-015 Port almost_empty, output, 1, count <= AEMPTY_TH.
REQ-016 Port count, output, $clog2(DEPTH+1), current occupancy.
REQ-017 Port overflow, output, 1, sticky: write dropped while full.
REQ-018 Port underflow, output, 1, sticky: read attempted while empty.

Function
REQ-019 Storage SHALL be a DEPTH-entry array addressed by write and read pointers, each 0..DEPTH-1, wrapping DEPTH-1 -> 0.
REQ-020 data_out SHALL show entry at read pointer combinationally whenever empty=0, and SHALL be all-zero while empty=1.
REQ-021 Accepted write: shift_in=1 and (full=0 or shift_out=1); stores data_in at write pointer, advances write pointer.
REQ-022 Accepted read: shift_out=1 and empty=0; advances read pointer; the popped word is the data_out value in that cycle.
REQ-023 count SHALL increment on write-only, decrement on read-only, hold on both-or-neither accepted.
REQ-024 Full with shift_in=1 and shift_out=1: both accepted, count stays DEPTH, no overflow.
REQ-025 Empty with shift_in=1 and shift_out=1: write accepted, read rejected, count -> 1, underflow set.
REQ-026 Full with shift_in=1, shift_out=0: data dropped, state unchanged, overflow set next edge.
REQ-027 Empty with shift_out=1: state unchanged, underflow set next edge.
REQ-028 full, empty, almost_full, almost_empty SHALL be decoded from registered count; valid in the cycle following the updating edge, no extra latency.
REQ-029 overflow/underflow SHALL remain 1 until clr_err=1 or reset; if a new error and clr_err coincide, the flag SHALL be 1 after the edge.
REQ-030 Write latency: word written at edge N SHALL appear on data_out after edge N if the queue was empty.

Reset
REQ-031 res_n=0 SHALL immediately, without clock, force pointers=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, data_out=0.
REQ-032 Storage contents SHALL not be reset; reset mid-operation discards all queued words.
REQ-033 Requests SHALL be ignored while res_n=0; operation resumes on the first rising edge after deassertion.

Verification (WIDTH=8, DEPTH=4, AFULL_TH=3, AEMPTY_TH=1)
REQ-034 Write 0x11,0x22,0x33,0x44 -> count 1,2,3,4; almost_full at count 3; full at 4; data_out=0x11 throughout.
REQ-035 Full, shift_in=1 with 0x55, shift_out=0 -> count stays 4, overflow=1; subsequent reads return 0x11..0x44 in order, then empty=1, data_out=0.
REQ-036 Full, shift_in=shift_out=1 with 0x66 -> 0x11 popped, count 4; drain yields 0x22,0x33,0x44,0x66 (pointer wrap verified).
REQ-037 Empty, shift_in=shift_out=1 with 0x77 -> count 1, underflow=1, data_out=0x77; clr_err=1 one cycle -> underflow=0.
REQ-038 Count 3, assert res_n=0 between edges -> outputs take REQ-031 values before next edge; after release, write 0x99 -> data_out=0x99, count 1.
REQ-039 Random shift_in/shift_out over 1000 words checked against reference queue model: data order, count, and all flags match every cycle.
